// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALU control codes, alu_op classes,
// R-type funct values and forwarding-select codes.
package mips_pkg;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_RTYPE = 2'b10,
      ALU_OP_SLTI  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG     = 2'b00,
      FWD_MEMWB   = 2'b01,
      FWD_EXMEM   = 2'b10,
      FWD_REG_ALT = 2'b11
   } fwd_sel_e;

   localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
   localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
   localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
   localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
   localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;
   localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
   localparam logic [3:0] ALU_CTRL_INV = 4'b1111;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode: alu_op class plus R-type funct to the
// 4-bit ALU control code; flags an unknown funct on a valid instruction.
module alu_ctrl_dec
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   input  logic       valid,
   output logic [3:0] alu_ctrl,
   output logic       illegal
);

   logic funct_unknown;

   always_comb begin
      alu_ctrl      = ALU_CTRL_INV;
      funct_unknown = 1'b0;
      case (alu_op_e'(alu_op))
         ALU_OP_ADD:  alu_ctrl = ALU_CTRL_ADD;
         ALU_OP_SUB:  alu_ctrl = ALU_CTRL_SUB;
         ALU_OP_SLTI: alu_ctrl = ALU_CTRL_SLT;
         default: begin
            case (funct)
               FUNCT_ADD: alu_ctrl = ALU_CTRL_ADD;
               FUNCT_SUB: alu_ctrl = ALU_CTRL_SUB;
               FUNCT_AND: alu_ctrl = ALU_CTRL_AND;
               FUNCT_OR:  alu_ctrl = ALU_CTRL_OR;
               FUNCT_NOR: alu_ctrl = ALU_CTRL_NOR;
               FUNCT_SLT: alu_ctrl = ALU_CTRL_SLT;
               default: begin
                  alu_ctrl      = ALU_CTRL_INV;
                  funct_unknown = 1'b1;
               end
            endcase
         end
      endcase
   end

   // A bubble never reports an illegal instruction.
   assign illegal = funct_unknown & valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and ALU control decode.
// Forwarding muxes are built only when ID_EX_FWD_EN is defined.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          id_valid_i,
   input  logic [DW-1:0] rs_data_i,
   input  logic [DW-1:0] rt_data_i,
   input  logic [DW-1:0] imm_i,
   input  logic [RW-1:0] rt_addr_i,
   input  logic [RW-1:0] rd_addr_i,
   input  logic [5:0]    funct_i,
   input  logic [1:0]    alu_op_i,
   input  logic          alu_src_i,
   input  logic          reg_dst_i,
   input  logic          reg_write_i,
   input  logic          mem_read_i,
   input  logic          mem_write_i,
   input  logic          mem_to_reg_i,
   input  logic [1:0]    fwd_a_i,
   input  logic [1:0]    fwd_b_i,
   input  logic [DW-1:0] exmem_result_i,
   input  logic [DW-1:0] memwb_result_i,
   output logic [DW-1:0] alu_src1_o,
   output logic [DW-1:0] alu_src2_o,
   output logic [3:0]    alu_ctrl_o,
   output logic [DW-1:0] store_data_o,
   output logic [RW-1:0] dst_addr_o,
   output logic          valid_o,
   output logic          reg_write_o,
   output logic          mem_read_o,
   output logic          mem_write_o,
   output logic          mem_to_reg_o,
   output logic          illegal_o
);

   logic [DW-1:0] rs_q, rt_q, imm_q;
   logic [RW-1:0] dst_q;
   logic [5:0]    funct_q;
   logic [1:0]    alu_op_q;
   logic          alu_src_q;
   logic          valid_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic [DW-1:0] op_a, op_b;

   // Flush clears only valid and control bits; data registers keep stale values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rs_q         <= '0;
         rt_q         <= '0;
         imm_q        <= '0;
         dst_q        <= '0;
         funct_q      <= '0;
         alu_op_q     <= '0;
         alu_src_q    <= 1'b0;
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else if (flush_i) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else if (!stall_i) begin
         rs_q         <= rs_data_i;
         rt_q         <= rt_data_i;
         imm_q        <= imm_i;
         dst_q        <= reg_dst_i ? rd_addr_i : rt_addr_i;
         funct_q      <= funct_i;
         alu_op_q     <= alu_op_i;
         alu_src_q    <= alu_src_i;
         valid_q      <= id_valid_i;
         reg_write_q  <= id_valid_i & reg_write_i;
         mem_read_q   <= id_valid_i & mem_read_i;
         mem_write_q  <= id_valid_i & mem_write_i;
         mem_to_reg_q <= id_valid_i & mem_to_reg_i;
      end
   end

`ifdef ID_EX_FWD_EN
   always_comb begin
      op_a = rs_q;
      case (fwd_sel_e'(fwd_a_i))
         FWD_MEMWB: op_a = memwb_result_i;
         FWD_EXMEM: op_a = exmem_result_i;
         default:   op_a = rs_q;
      endcase
   end

   always_comb begin
      op_b = rt_q;
      case (fwd_sel_e'(fwd_b_i))
         FWD_MEMWB: op_b = memwb_result_i;
         FWD_EXMEM: op_b = exmem_result_i;
         default:   op_b = rt_q;
      endcase
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_a_i, fwd_b_i, exmem_result_i, memwb_result_i};
   assign op_a = rs_q;
   assign op_b = rt_q;
`endif

   assign alu_src1_o   = op_a;
   assign alu_src2_o   = alu_src_q ? imm_q : op_b;
   assign store_data_o = op_b;
   assign dst_addr_o   = dst_q;
   assign valid_o      = valid_q;
   assign reg_write_o  = reg_write_q;
   assign mem_read_o   = mem_read_q;
   assign mem_write_o  = mem_write_q;
   assign mem_to_reg_o = mem_to_reg_q;

   alu_ctrl_dec u_alu_ctrl_dec (
      .alu_op   (alu_op_q),
      .funct    (funct_q),
      .valid    (valid_q),
      .alu_ctrl (alu_ctrl_o),
      .illegal  (illegal_o)
   );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; forwarding expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst, stall, flush, id_valid;
   logic [DW-1:0] rs_data, rt_data, imm;
   logic [RW-1:0] rt_addr, rd_addr;
   logic [5:0]    funct;
   logic [1:0]    alu_op;
   logic          alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
   logic [1:0]    fwd_a, fwd_b;
   logic [DW-1:0] exmem_result, memwb_result;
   logic [DW-1:0] alu_src1, alu_src2, store_data;
   logic [3:0]    alu_ctrl;
   logic [RW-1:0] dst_addr;
   logic          valid, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, illegal;

   always #5 clk = ~clk;

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
      .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
      .rt_addr_i(rt_addr), .rd_addr_i(rd_addr), .funct_i(funct), .alu_op_i(alu_op),
      .alu_src_i(alu_src), .reg_dst_i(reg_dst), .reg_write_i(reg_write),
      .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_to_reg_i(mem_to_reg),
      .fwd_a_i(fwd_a), .fwd_b_i(fwd_b),
      .exmem_result_i(exmem_result), .memwb_result_i(memwb_result),
      .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
      .store_data_o(store_data), .dst_addr_o(dst_addr), .valid_o(valid),
      .reg_write_o(reg_write_q), .mem_read_o(mem_read_q), .mem_write_o(mem_write_q),
      .mem_to_reg_o(mem_to_reg_q), .illegal_o(illegal)
   );

   typedef struct {
      logic [DW-1:0] src1, src2, store;
      logic [3:0]    ctrl;
      logic [RW-1:0] dst;
      logic          valid, rw, mr, mw, m2r, illegal;
      bit            data_known;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state of the pipeline register.
   logic [DW-1:0] m_rs, m_rt, m_imm;
   logic [RW-1:0] m_dst;
   logic [5:0]    m_funct;
   logic [1:0]    m_op;
   logic          m_src, m_valid, m_rw, m_mr, m_mw, m_m2r;
   bit            m_known;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ctrl_ref(input logic [1:0] op, input logic [5:0] f);
      case (op)
         2'b00: return 4'b0010;
         2'b01: return 4'b0110;
         2'b11: return 4'b0111;
         default:
            case (f)
               6'b100000: return 4'b0010;
               6'b100010: return 4'b0110;
               6'b100100: return 4'b0000;
               6'b100101: return 4'b0001;
               6'b100111: return 4'b1100;
               6'b101010: return 4'b0111;
               default:   return 4'b1111;
            endcase
      endcase
   endfunction

   function automatic logic [DW-1:0] fwd_ref(input logic [1:0] sel, input logic [DW-1:0] reg_val);
`ifdef ID_EX_FWD_EN
      case (sel)
         2'b01:   return memwb_result;
         2'b10:   return exmem_result;
         default: return reg_val;
      endcase
`else
      return reg_val;
`endif
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      logic [DW-1:0] b;
      b            = fwd_ref(fwd_b, m_rt);
      e.src1       = fwd_ref(fwd_a, m_rs);
      e.src2       = m_src ? m_imm : b;
      e.store      = b;
      e.ctrl       = ctrl_ref(m_op, m_funct);
      e.dst        = m_dst;
      e.valid      = m_valid;
      e.rw         = m_rw;
      e.mr         = m_mr;
      e.mw         = m_mw;
      e.m2r        = m_m2r;
      e.illegal    = m_valid && (m_op == 2'b10) && (e.ctrl == 4'b1111);
      e.data_known = m_known;
      return e;
   endfunction

   task automatic step_model();
      if (!rst) begin
         m_rs = '0; m_rt = '0; m_imm = '0; m_dst = '0; m_funct = '0; m_op = '0;
         m_src = 0; m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
         m_known = 1;
      end else if (flush) begin
         m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
         m_known = 0;
      end else if (!stall) begin
         m_rs = rs_data; m_rt = rt_data; m_imm = imm;
         m_dst = reg_dst ? rd_addr : rt_addr;
         m_funct = funct; m_op = alu_op; m_src = alu_src;
         m_valid = id_valid;
         m_rw = id_valid & reg_write; m_mr = id_valid & mem_read;
         m_mw = id_valid & mem_write; m_m2r = id_valid & mem_to_reg;
         m_known = 1;
      end
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check("valid", valid, e.valid);
      check("reg_write", reg_write_q, e.rw);
      check("mem_read", mem_read_q, e.mr);
      check("mem_write", mem_write_q, e.mw);
      check("mem_to_reg", mem_to_reg_q, e.m2r);
      check("illegal", illegal, e.illegal);
      if (e.data_known) begin
         check("src1", alu_src1, e.src1);
         check("src2", alu_src2, e.src2);
         check("store", store_data, e.store);
         check("ctrl", alu_ctrl, e.ctrl);
         check("dst", dst_addr, e.dst);
      end
   endtask

   task automatic tick();
      step_model();
      sb.push_back(expect_now());
      @(posedge clk);
      #1;
      compare_front();
   endtask

   task automatic settle();
      sb.push_back(expect_now());
      #1;
      compare_front();
   endtask

   task automatic rand_id();
      logic [5:0] legal [6];
      legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
      id_valid   = 1'($urandom_range(0, 3) != 0);
      rs_data    = $urandom;
      rt_data    = $urandom;
      imm        = $urandom;
      rt_addr    = 5'($urandom);
      rd_addr    = 5'($urandom);
      funct      = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 5)] : 6'($urandom);
      alu_op     = 2'($urandom);
      alu_src    = 1'($urandom);
      reg_dst    = 1'($urandom);
      reg_write  = 1'($urandom);
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      mem_to_reg = 1'($urandom);
   endtask

   initial begin
      m_known = 0;
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
      fwd_a = 2'b00; fwd_b = 2'b00;
      exmem_result = $urandom; memwb_result = $urandom;

      // Reset overrides random stall/flush.
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_id();
         stall = 1'($urandom); flush = 1'($urandom);
         tick();
      end
      check("rst_valid", valid, 1'b0);
      check("rst_dst", dst_addr, 5'd0);
      check("rst_src1", alu_src1, 32'd0);

      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      rand_id();
      id_valid = 1'b1;
      tick();

      // R-type sub.
      rs_data = 32'd5; rt_data = 32'd3; funct = 6'b100010; alu_op = 2'b10;
      reg_dst = 1'b1; rd_addr = 5'd7; rt_addr = 5'd2; alu_src = 1'b0;
      id_valid = 1'b1; reg_write = 1'b1; mem_read = 0; mem_write = 0; mem_to_reg = 0;
      tick();
      check("rtype_src1", alu_src1, 32'd5);
      check("rtype_src2", alu_src2, 32'd3);
      check("rtype_ctrl", alu_ctrl, 4'b0110);
      check("rtype_dst", dst_addr, 5'd7);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         tick();
      end
      check("stall_src1", alu_src1, 32'd5);
      check("stall_dst", dst_addr, 5'd7);

      flush = 1'b1;
      tick();
      check("flush_valid", valid, 1'b0);
      check("flush_rw", reg_write_q, 1'b0);

      // Forwarding on operand A.
      stall = 1'b0; flush = 1'b0;
      rand_id();
      id_valid = 1'b1; rs_data = 32'd1; rt_data = 32'd9; alu_op = 2'b00; alu_src = 1'b0;
      tick();
      exmem_result = 32'hAAAA_0000; memwb_result = 32'h0000_5555;
      fwd_a = 2'b10; settle();
`ifdef ID_EX_FWD_EN
      check("fwd_exmem", alu_src1, 32'hAAAA_0000);
`else
      check("fwd_exmem", alu_src1, 32'd1);
`endif
      fwd_a = 2'b01; settle();
`ifdef ID_EX_FWD_EN
      check("fwd_memwb", alu_src1, 32'h0000_5555);
`else
      check("fwd_memwb", alu_src1, 32'd1);
`endif
      fwd_a = 2'b11; settle();
      check("fwd_reg11", alu_src1, 32'd1);
      fwd_a = 2'b00;

      // sw: immediate operand, forwarded store data.
      rand_id();
      id_valid = 1'b1; alu_src = 1'b1; imm = 32'd8; rt_data = 32'h1234; alu_op = 2'b00;
      mem_write = 1'b1; reg_write = 1'b0;
      tick();
      fwd_b = 2'b10; settle();
      check("sw_src2", alu_src2, 32'd8);
`ifdef ID_EX_FWD_EN
      check("sw_store", store_data, 32'hAAAA_0000);
`else
      check("sw_store", store_data, 32'h1234);
`endif
      fwd_b = 2'b00;

      // Unknown funct, then the same instruction flushed.
      id_valid = 1'b1; alu_op = 2'b10; funct = 6'b000000;
      tick();
      check("illegal_ctrl", alu_ctrl, 4'b1111);
      check("illegal_set", illegal, 1'b1);
      flush = 1'b1;
      tick();
      check("illegal_bubble", illegal, 1'b0);
      flush = 1'b0;

      // Invalid instruction suppresses its control bits.
      id_valid = 1'b0; reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1;
      tick();

      for (int i = 0; i < 60; i++) begin
         rand_id();
         rst   = 1'($urandom_range(0, 19) != 0);
         stall = 1'($urandom_range(0, 3) == 0);
         flush = 1'($urandom_range(0, 7) == 0);
         fwd_a = 2'($urandom); fwd_b = 2'($urandom);
         exmem_result = $urandom; memwb_result = $urandom;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
